// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: FSM encoding,
// parity-mode codes and the default oversampling ratio.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int OS_TICK_DEF = 16;

  // 2'b11 is a second encoding of "no parity".
  function automatic logic par_enabled(input logic [1:0] mode);
    return !((mode == PAR_NONE) || (mode == 2'b11));
  endfunction

  function automatic logic par_value(input logic [1:0] mode, input logic xor_all);
    return (mode == PAR_ODD) ? ~xor_all : xor_all;
  endfunction

endpackage

// File: rtl/uart_tx_hold.sv
// One-entry valid/ready holding register for {din, par_mode}; lets the next
// frame wait while the shifter is still sending the current one.
module uart_tx_hold #(
  parameter int DBIT = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            put,
  input  logic            take,
  input  logic [DBIT-1:0] din,
  input  logic [1:0]      par_mode,
  output logic            ready,
  output logic            full,
  output logic [DBIT-1:0] data,
  output logic [1:0]      mode
);

  logic accept;

  assign accept = put && !full;
  assign ready  = !full;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset)       full <= 1'b0;
    else if (take)   full <= 1'b0;
    else if (accept) full <= 1'b1;
  end

  // NOTE: the payload is deliberately left unreset; it is only ever read
  // while full=1, and reset clears full, which discards it.
  always_ff @(posedge clk) begin
    if (accept) begin
      data <= din;
      mode <= par_mode;
    end
  end

endmodule

// File: rtl/uart_tx_fmt.sv
// UART transmitter with configurable data width, runtime parity, configurable
// stop length and a one-entry holding register for gapless back-to-back frames.
module uart_tx_fmt
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int OS_TICK = OS_TICK_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  input  logic [1:0]      par_mode,
  output logic            tx_ready,
  output logic            tx,
  output logic            tx_done_tick,
  output logic            busy
);

  localparam int CW = $clog2((SB_TICK > OS_TICK) ? SB_TICK : OS_TICK);
  localparam int BW = $clog2(DBIT);
  localparam logic [CW-1:0] OS_LAST  = CW'(OS_TICK - 1);
  localparam logic [CW-1:0] SB_LAST  = CW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);

  state_t          state, state_n;
  logic [CW-1:0]   tick, tick_n;
  logic [BW-1:0]   bit_cnt, bit_n;
  logic [DBIT-1:0] shift, shift_n;
  logic            par_bit, par_bit_n;
  logic            par_en, par_en_n;
  logic            tx_n, done_n, load, bit_end;

  logic            hold_full;
  logic [DBIT-1:0] hold_data;
  logic [1:0]      hold_mode;

  uart_tx_hold #(.DBIT(DBIT)) u_hold (
    .clk      (clk),
    .reset    (reset),
    .put      (tx_start),
    .take     (load),
    .din      (din),
    .par_mode (par_mode),
    .ready    (tx_ready),
    .full     (hold_full),
    .data     (hold_data),
    .mode     (hold_mode)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tick         <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      par_bit      <= 1'b0;
      par_en       <= 1'b0;
      tx           <= 1'b1;
      tx_done_tick <= 1'b0;
    end else begin
      state        <= state_n;
      tick         <= tick_n;
      bit_cnt      <= bit_n;
      shift        <= shift_n;
      par_bit      <= par_bit_n;
      par_en       <= par_en_n;
      tx           <= tx_n;
      tx_done_tick <= done_n;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n   = state;
    tick_n    = tick;
    bit_n     = bit_cnt;
    shift_n   = shift;
    par_bit_n = par_bit;
    par_en_n  = par_en;
    tx_n      = 1'b1;
    done_n    = 1'b0;
    load      = 1'b0;
    bit_end   = s_tick && (tick == ((state == STOP) ? SB_LAST : OS_LAST));

    if (s_tick && state != IDLE) tick_n = tick + 1'b1;

    unique case (state)
      IDLE: load = hold_full;
      START: begin
        tx_n = 1'b0;
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        tx_n = shift[0];
        if (bit_end) begin
          shift_n = shift >> 1;
          if (bit_cnt == BIT_LAST) begin
            bit_n   = '0;
            state_n = par_en ? PARITY : STOP;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        tx_n = par_bit;
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        if (bit_end) begin
          done_n = 1'b1;
          // A waiting word starts in the same cycle, so frames abut with no gap.
          if (hold_full) load = 1'b1;
          else           state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (bit_end) tick_n = '0;

    if (load) begin
      shift_n   = hold_data;
      par_bit_n = par_value(hold_mode, ^hold_data);
      par_en_n  = par_enabled(hold_mode);
      tick_n    = '0;
      bit_n     = '0;
      state_n   = START;
    end
  end

endmodule

// File: tb/tb_uart_tx_fmt.sv
// Directed bench for uart_tx_fmt: an 8-bit/1-stop instance and a 7-bit/2-stop
// instance share clk, reset and a 1-in-4 s_tick, so one bit period is 64 clks.
module tb_uart_tx_fmt;
  import uart_pkg::*;

  localparam int BP = 64;

  logic clk = 1'b0;
  logic reset, s_tick;
  int   ph = 0;

  logic       tx_start8, tx_start7;
  logic [7:0] din8;
  logic [6:0] din7;
  logic [1:0] par8, par7;
  logic       tx_ready8, tx8, done8, busy8;
  logic       tx_ready7, tx7, done7, busy7;

  logic sel;
  logic tx_mon, ready_mon, done_mon, busy_mon;
  assign tx_mon    = sel ? tx7       : tx8;
  assign ready_mon = sel ? tx_ready7 : tx_ready8;
  assign done_mon  = sel ? done7     : done8;
  assign busy_mon  = sel ? busy7     : busy8;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_fmt #(.DBIT(8), .SB_TICK(16), .OS_TICK(16)) dut8 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start8),
    .din(din8), .par_mode(par8), .tx_ready(tx_ready8), .tx(tx8),
    .tx_done_tick(done8), .busy(busy8)
  );

  uart_tx_fmt #(.DBIT(7), .SB_TICK(32), .OS_TICK(16)) dut7 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start7),
    .din(din7), .par_mode(par7), .tx_ready(tx_ready7), .tx(tx7),
    .tx_done_tick(done7), .busy(busy7)
  );

  always #5 clk = ~clk;

  initial begin
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph     = (ph + 1) % 4;
      s_tick = (ph == 3);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        sel;
    logic [7:0]  din;
    logic [1:0]  mode;
    logic [15:0] exp_bits;
    int          nper;
    string       name;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] m);
    if (sel) begin
      tx_start7 = v; din7 = d[6:0]; par7 = m;
    end else begin
      tx_start8 = v; din8 = d;      par8 = m;
    end
  endtask

  // Accept lands one clk before a tick edge, so the load edge is itself a
  // tick edge and every later bit boundary falls on a 64-clk grid.
  task automatic send_aligned(input logic [7:0] d, input logic [1:0] m);
    @(negedge clk);
    while (!s_tick) @(negedge clk);
    repeat (3) @(negedge clk);
    check("ready_before_accept", ready_mon, 1);
    drive(1'b1, d, m);
    @(negedge clk);
    drive(1'b0, 8'h00, 2'b00);
    check("ready_after_accept", ready_mon, 0);
    check("busy_after_accept", busy_mon, 0);
    check("tx_idle_after_accept", tx_mon, 1);
    @(negedge clk);
    check("ready_after_load", ready_mon, 1);
    check("busy_after_load", busy_mon, 1);
    check("tx_high_after_load", tx_mon, 1);
  endtask

  task automatic capture(input int nper, output logic [15:0] bits,
                         output int done_n, output int done_cnt, output int idle);
    bits = '0; done_n = -1; done_cnt = 0; idle = 0;
    do begin
      @(negedge clk);
      idle++;
    end while (tx_mon && idle < 3000);
    check("start_bit_seen", tx_mon, 0);
    if (tx_mon) return;
    for (int n = 0; n < nper * BP; n++) begin
      if (n > 0) @(negedge clk);
      if (n % BP == BP / 2) bits[n / BP] = tx_mon;
      if (done_mon) begin
        if (done_cnt == 0) done_n = n;
        done_cnt++;
      end
    end
  endtask

  task automatic run_frame(input vec_t v, input int exp_idle);
    logic [15:0] bits;
    int done_n, done_cnt, idle;
    capture(v.nper, bits, done_n, done_cnt, idle);
    check({v.name, "_bits"}, {16'h0, bits}, {16'h0, v.exp_bits});
    check({v.name, "_done_count"}, done_cnt, 1);
    check({v.name, "_done_offset"}, done_n, v.nper * BP - 1);
    check({v.name, "_start_latency"}, idle, exp_idle);
  endtask

  initial begin
    vec_t b2b1, b2b2, after_rst;
    int   lows, dones, w;
    logic early;

    // Expected bit vectors: bit0 = start, then data LSB first, parity, stop(s).
    vecs[0] = '{1'b0, 8'h55, 2'b00, 16'h02AA, 10, "8n1_55"};
    vecs[1] = '{1'b0, 8'hA5, 2'b01, 16'h054A, 11, "even_A5"};
    vecs[2] = '{1'b0, 8'hA5, 2'b10, 16'h074A, 11, "odd_A5"};
    vecs[3] = '{1'b0, 8'hA5, 2'b11, 16'h034A, 10, "none11_A5"};
    vecs[4] = '{1'b0, 8'h00, 2'b10, 16'h0600, 11, "odd_00"};
    vecs[5] = '{1'b0, 8'hFF, 2'b01, 16'h05FE, 11, "even_FF"};
    vecs[6] = '{1'b0, 8'h07, 2'b10, 16'h040E, 11, "odd_07"};
    vecs[7] = '{1'b1, 8'h41, 2'b00, 16'h0382, 10, "d7s2_41"};
    b2b1      = '{1'b0, 8'h12, 2'b00, 16'h0224, 10, "b2b_first"};
    b2b2      = '{1'b0, 8'h34, 2'b00, 16'h0268, 10, "b2b_second"};
    after_rst = '{1'b0, 8'h0F, 2'b00, 16'h021E, 10, "after_reset_0F"};

    reset = 1'b1;
    tx_start8 = 1'b0; din8 = '0; par8 = '0;
    tx_start7 = 1'b0; din7 = '0; par7 = '0;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      check("reset_tx", tx_mon, 1);
      check("reset_ready", ready_mon, 1);
      check("reset_done", done_mon, 0);
      check("reset_busy", busy_mon, 0);
    end
    reset = 1'b0;
    sel   = 1'b0;

    for (int i = 0; i < 8; i++) begin
      sel = vecs[i].sel;
      send_aligned(vecs[i].din, vecs[i].mode);
      run_frame(vecs[i], 1);
      check({vecs[i].name, "_busy_end"}, busy_mon, 0);
    end
    sel = 1'b0;

    // Back-to-back: 0x34 waits in holding, 0x77 arrives while full and is dropped.
    send_aligned(8'h12, PAR_NONE);
    fork
      begin
        run_frame(b2b1, 1);
        run_frame(b2b2, 1);
      end
      begin
        repeat (100) @(negedge clk);
        check("b2b_ready_mid_frame", ready_mon, 1);
        drive(1'b1, 8'h34, PAR_NONE);
        @(negedge clk);
        drive(1'b0, 8'h00, 2'b00);
        check("b2b_ready_after_accept", ready_mon, 0);
        repeat (50) @(negedge clk);
        drive(1'b1, 8'h77, PAR_EVEN);
        @(negedge clk);
        drive(1'b0, 8'h00, 2'b00);
        check("b2b_ready_after_ignored", ready_mon, 0);
        early = 1'b0;
        w = 0;
        while (!done_mon && w < 1000) begin
          if (ready_mon) early = 1'b1;
          @(negedge clk);
          w++;
        end
        check("b2b_ready_held_low", early, 0);
        check("b2b_first_done_seen", done_mon, 1);
        check("b2b_ready_after_reload", ready_mon, 1);
      end
    join
    lows = 0;
    repeat (800) begin
      @(negedge clk);
      if (!tx_mon) lows++;
    end
    check("b2b_third_start_ignored", lows, 0);

    // Reset during data bit 3 of 0xF0, with 0x99 waiting in holding.
    send_aligned(8'hF0, PAR_NONE);
    @(negedge clk);
    check("rst_start_bit", tx_mon, 0);
    repeat (10) @(negedge clk);
    drive(1'b1, 8'h99, PAR_EVEN);
    @(negedge clk);
    drive(1'b0, 8'h00, 2'b00);
    check("rst_holding_full", ready_mon, 0);
    repeat (4 * BP + BP / 2 - 11) @(negedge clk);
    check("rst_data_bit3", tx_mon, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_abort_tx", tx_mon, 1);
    check("rst_abort_ready", ready_mon, 1);
    check("rst_abort_busy", busy_mon, 0);
    lows  = 0;
    dones = 0;
    repeat (800) begin
      @(negedge clk);
      if (!tx_mon) lows++;
      if (done_mon) dones++;
    end
    check("rst_no_done", dones, 0);
    check("rst_holding_discarded", lows, 0);
    send_aligned(8'h0F, PAR_NONE);
    run_frame(after_rst, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
